adc_capture_ctl: RTL and testbench

//  Parametrised multi-channel raw-ADC capture sequencer for the digitizer path; generalises the one-shot banyan fill.

---
 rtl/adc_capture_ctl.sv | 227 ++++++++++++++++++++++
 tb/tb_adc_capture_ctl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_ctl.sv
// adc_capture_ctl: decimating NCH-lane ADC capture sequencer driving an external 2^AW-deep sample-buffer write port.
// Optional trigger timestamping is enabled by defining CAPTURE_TIMESTAMP_EN.
module adc_capture_ctl #(
    parameter int NCH = 8,
    parameter int DW  = 16,
    parameter int AW  = 14,
    parameter int RW  = 10
) (
    input  logic              adc_clk,
    input  logic              adc_rst_n,
    input  logic [NCH*DW-1:0] adc_data,
    input  logic              adc_valid,
    input  logic              arm,
    input  logic              trig,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [NCH-1:0]    chan_mask,
    input  logic [RW-1:0]     decim,
    input  logic [AW-1:0]     pre_len,
    output logic              wr_en,
    output logic [AW-1:0]     wr_addr,
    output logic [NCH*DW-1:0] wr_data,
    output logic              running,
    output logic              full,
    output logic              done,
    output logic [AW-1:0]     trig_ptr,
    output logic [31:0]       trig_ts
);

    localparam logic [1:0]    ST_IDLE  = 2'd0;
    localparam logic [1:0]    ST_ARMED = 2'd1;
    localparam logic [1:0]    ST_POST  = 2'd2;
    localparam logic [1:0]    ST_DONE  = 2'd3;
    localparam logic [AW:0]   DEPTH    = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_MAX  = {AW{1'b1}};
    localparam logic [RW-1:0] DCNT_ONE = {{(RW-1){1'b0}}, 1'b1};

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [1:0]        arm_mode_s;
    logic [1:0]        mode_r;
    logic [NCH-1:0]    mask_r;
    logic [AW-1:0]     pre_len_r;
    logic [RW-1:0]     dcnt_r;
    logic [RW-1:0]     decim_r;
    logic [AW-1:0]     ptr_r;
    logic [AW:0]       post_left_r;
    logic [AW:0]       post_len_s;
    logic              wr_en_r;
    logic [AW-1:0]     wr_addr_r;
    logic [NCH*DW-1:0] wr_data_r;
    logic              full_r;
    logic              running_r;
    logic              done_r;
    logic [AW-1:0]     trig_ptr_r;
    logic              keep_s;
    logic              capturing_s;
    logic              trig_acc_s;
    logic              write_s;
    logic              last_write_s;

    function automatic logic [NCH*DW-1:0] mask_lanes(input logic [NCH*DW-1:0] data,
                                                     input logic [NCH-1:0]    mask);
        logic [NCH*DW-1:0] res;
        res = data;
        for (int k = 0; k < NCH; k++) begin
            if (!mask[k]) begin
                res[k*DW +: DW] = {DW{1'b0}};
            end else begin
                res[k*DW +: DW] = data[k*DW +: DW];
            end
        end
        return res;
    endfunction

    assign keep_s      = adc_valid && (dcnt_r == {RW{1'b0}});
    assign capturing_s = (state_r == ST_ARMED) || (state_r == ST_POST);
    assign trig_acc_s  = trig && !arm && !stop && (state_r == ST_ARMED) && (mode_r == 2'd2);
    assign write_s     = keep_s && capturing_s && !arm && !stop;
    // the sample written in the trigger cycle is the first post-trigger word
    assign post_len_s  = DEPTH - {1'b0, pre_len_r};
    assign last_write_s = write_s &&
                          (((state_r == ST_POST) && (post_left_r == CNT_ONE)) ||
                           (trig_acc_s && (post_len_s == CNT_ONE)));

    // reserved mode value behaves as one-shot
    always_comb begin
        case (mode)
            2'd1:    arm_mode_s = 2'd1;
            2'd2:    arm_mode_s = 2'd2;
            default: arm_mode_s = 2'd0;
        endcase
    end

    // next-state selection: arm beats stop, stop beats trigger
    always_comb begin
        state_nxt_s = state_r;
        if (arm) begin
            state_nxt_s = (arm_mode_s == 2'd0) ? ST_POST : ST_ARMED;
        end else if (stop) begin
            state_nxt_s = ST_IDLE;
        end else if (last_write_s) begin
            state_nxt_s = ST_DONE;
        end else if (trig_acc_s) begin
            state_nxt_s = ST_POST;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // state register and registered status flags
    always_ff @(posedge adc_clk or negedge adc_rst_n) begin
        if (!adc_rst_n) begin
            state_r   <= ST_IDLE;
            running_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            running_r <= (state_nxt_s == ST_ARMED) || (state_nxt_s == ST_POST);
            done_r    <= (state_nxt_s == ST_DONE);
        end
    end

    // decimation counter; a new ratio is picked up on arm or at each wrap
    always_ff @(posedge adc_clk or negedge adc_rst_n) begin
        if (!adc_rst_n) begin
            dcnt_r  <= {RW{1'b0}};
            decim_r <= {RW{1'b0}};
        end else if (arm) begin
            dcnt_r  <= {RW{1'b0}};
            decim_r <= decim;
        end else if (adc_valid) begin
            if (dcnt_r >= decim_r) begin
                dcnt_r  <= {RW{1'b0}};
                decim_r <= decim;
            end else begin
                dcnt_r  <= dcnt_r + DCNT_ONE;
            end
        end
    end

    // write pipeline stage and buffer pointer
    always_ff @(posedge adc_clk or negedge adc_rst_n) begin
        if (!adc_rst_n) begin
            wr_en_r   <= 1'b0;
            wr_addr_r <= {AW{1'b0}};
            wr_data_r <= {(NCH*DW){1'b0}};
            ptr_r     <= {AW{1'b0}};
            full_r    <= 1'b0;
        end else begin
            wr_en_r <= write_s;
            if (write_s) begin
                wr_addr_r <= ptr_r;
                wr_data_r <= mask_lanes(adc_data, mask_r);
            end
            if (arm) begin
                ptr_r  <= {AW{1'b0}};
                full_r <= 1'b0;
            end else if (write_s) begin
                ptr_r <= ptr_r + PTR_ONE;
                if (ptr_r == PTR_MAX) begin
                    full_r <= 1'b1;
                end
            end
        end
    end

    // configuration sampled on arm, trigger pointer and post-trigger word budget
    always_ff @(posedge adc_clk or negedge adc_rst_n) begin
        if (!adc_rst_n) begin
            mode_r      <= 2'd0;
            mask_r      <= {NCH{1'b0}};
            pre_len_r   <= {AW{1'b0}};
            trig_ptr_r  <= {AW{1'b0}};
            post_left_r <= {(AW+1){1'b0}};
        end else if (arm) begin
            mode_r    <= arm_mode_s;
            mask_r    <= chan_mask;
            pre_len_r <= pre_len;
            if (arm_mode_s == 2'd0) begin
                trig_ptr_r  <= {AW{1'b0}};
                post_left_r <= DEPTH;
            end
        end else if (trig_acc_s) begin
            trig_ptr_r  <= ptr_r;
            post_left_r <= write_s ? (post_len_s - CNT_ONE) : post_len_s;
        end else if (write_s && (state_r == ST_POST)) begin
            post_left_r <= post_left_r - CNT_ONE;
        end
    end

`ifdef CAPTURE_TIMESTAMP_EN
    logic [31:0] ts_cnt_r;
    logic [31:0] trig_ts_r;
    logic        ts_latch_s;

    assign ts_latch_s = (arm && (arm_mode_s == 2'd0)) || trig_acc_s;

    // free-running timestamp, captured on the accepted trigger
    always_ff @(posedge adc_clk or negedge adc_rst_n) begin
        if (!adc_rst_n) begin
            ts_cnt_r  <= 32'd0;
            trig_ts_r <= 32'd0;
        end else begin
            ts_cnt_r <= ts_cnt_r + 32'd1;
            if (ts_latch_s) begin
                trig_ts_r <= ts_cnt_r;
            end
        end
    end

    assign trig_ts = trig_ts_r;
`else
    assign trig_ts = 32'd0;
`endif

    assign wr_en    = wr_en_r;
    assign wr_addr  = wr_addr_r;
    assign wr_data  = wr_data_r;
    assign running  = running_r;
    assign full     = full_r;
    assign done     = done_r;
    assign trig_ptr = trig_ptr_r;

endmodule

// File: tb/tb_adc_capture_ctl.sv
// Scoreboard bench for adc_capture_ctl (AW=4): a transaction-level model predicts every buffer write and the status.
module tb_adc_capture_ctl;

    localparam int NCH   = 8;
    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int RW    = 10;
    localparam int W     = NCH * DW;
    localparam int DEPTH = 16;

    logic              adc_clk   = 1'b0;
    logic              adc_rst_n = 1'b0;
    logic [W-1:0]      adc_data  = '0;
    logic              adc_valid = 1'b0;
    logic              arm       = 1'b0;
    logic              trig      = 1'b0;
    logic              stop      = 1'b0;
    logic [1:0]        mode      = 2'd0;
    logic [NCH-1:0]    chan_mask = '0;
    logic [RW-1:0]     decim     = '0;
    logic [AW-1:0]     pre_len   = '0;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [W-1:0]      wr_data;
    logic              running;
    logic              full;
    logic              done;
    logic [AW-1:0]     trig_ptr;
    logic [31:0]       trig_ts;

    always #5 adc_clk = ~adc_clk;

    adc_capture_ctl #(.NCH(NCH), .DW(DW), .AW(AW), .RW(RW)) dut (
        .adc_clk   (adc_clk),
        .adc_rst_n (adc_rst_n),
        .adc_data  (adc_data),
        .adc_valid (adc_valid),
        .arm       (arm),
        .trig      (trig),
        .stop      (stop),
        .mode      (mode),
        .chan_mask (chan_mask),
        .decim     (decim),
        .pre_len   (pre_len),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .running   (running),
        .full      (full),
        .done      (done),
        .trig_ptr  (trig_ptr),
        .trig_ts   (trig_ts)
    );

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } wr_exp_t;

    typedef struct {
        int            cyc;
        logic          running;
        logic          done;
        logic          full;
        logic [AW-1:0] tptr;
        logic [31:0]   ts;
    } st_exp_t;

    typedef enum int {M_IDLE, M_ARMED, M_POST, M_DONE} mstate_t;

    wr_exp_t wq[$];
    st_exp_t sq[$];
    int      checks  = 0;
    int      errors  = 0;
    int      cyc     = 0;
    int      rst_cyc = 0;
    bit      mon_en  = 1'b0;

    // reference model: counts of samples and writes since arm, not pointers
    mstate_t        m_state;
    int             m_mode, m_pre, m_decim, m_vcnt, m_writes, m_post_writes, m_post_len;
    logic [NCH-1:0] m_mask;
    logic [AW-1:0]  m_tptr;
    logic           m_full;
    logic [31:0]    m_ts;

    always @(posedge adc_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [W-1:0] lane_mask(input logic [NCH-1:0] m);
        logic [W-1:0] r;
        for (int k = 0; k < NCH; k++) r[k*DW +: DW] = {DW{m[k]}};
        return r;
    endfunction

    task automatic model_reset();
        m_state = M_IDLE; m_mode = 0; m_pre = 0; m_decim = 0; m_vcnt = 0;
        m_writes = 0; m_post_writes = 0; m_post_len = DEPTH;
        m_mask = '0; m_tptr = '0; m_full = 1'b0; m_ts = 32'd0;
    endtask

    task automatic set_cfg(input int md, input logic [NCH-1:0] msk, input int dc, input int pl);
        mode = 2'(md); chan_mask = msk; decim = RW'(dc); pre_len = AW'(pl);
    endtask

    // one clock cycle: new data, model prediction for the coming edge, then wait
    task automatic tick();
        bit      keep;
        wr_exp_t we;
        st_exp_t se;
        adc_data = {$urandom, $urandom, $urandom, $urandom};
        if (arm) begin
            m_mode = (mode == 2'd3) ? 0 : int'(mode);
            m_mask = chan_mask; m_pre = int'(pre_len); m_decim = int'(decim);
            m_vcnt = 0; m_writes = 0; m_full = 1'b0;
            if (m_mode == 0) begin
                m_state = M_POST; m_tptr = '0; m_post_len = DEPTH; m_post_writes = 0;
                m_ts = 32'(cyc - rst_cyc);
            end else begin
                m_state = M_ARMED;
            end
        end else begin
            keep = adc_valid && ((m_vcnt % (m_decim + 1)) == 0);
            if (adc_valid) m_vcnt++;
            if (stop) begin
                m_state = M_IDLE;
            end else if (m_state == M_ARMED || m_state == M_POST) begin
                if (trig && m_state == M_ARMED && m_mode == 2) begin
                    m_state = M_POST; m_tptr = AW'(m_writes % DEPTH);
                    m_post_len = DEPTH - m_pre; m_post_writes = 0;
                    m_ts = 32'(cyc - rst_cyc);
                end
                if (keep) begin
                    we.cyc = cyc + 1; we.addr = AW'(m_writes % DEPTH);
                    we.data = adc_data & lane_mask(m_mask);
                    wq.push_back(we);
                    m_writes++;
                    if (m_writes >= DEPTH) m_full = 1'b1;
                    if (m_state == M_POST) begin
                        m_post_writes++;
                        if (m_post_writes == m_post_len) m_state = M_DONE;
                    end
                end
            end
        end
        se.cyc = cyc + 1;
        se.running = (m_state == M_ARMED) || (m_state == M_POST);
        se.done = (m_state == M_DONE);
        se.full = m_full;
        se.tptr = m_tptr;
`ifdef CAPTURE_TIMESTAMP_EN
        se.ts = m_ts;
`else
        se.ts = 32'd0;
`endif
        sq.push_back(se);
        @(negedge adc_clk);
        arm = 1'b0; trig = 1'b0; stop = 1'b0;
    endtask

    // monitor: pops expectations whenever the DUT presents a write or a status cycle
    always @(negedge adc_clk) begin
        wr_exp_t e;
        st_exp_t s;
        if (mon_en) begin
            if (wr_en) begin
                if (wq.size() == 0) begin
                    chk("unexpected_wr_en", W'(1), W'(0));
                end else begin
                    e = wq.pop_front();
                    chk("wr_cycle", W'(cyc), W'(e.cyc));
                    chk("wr_addr", W'(wr_addr), W'(e.addr));
                    chk("wr_data", wr_data, e.data);
                end
            end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
                e = wq.pop_front();
                chk("missing_wr_en", W'(0), W'(1));
            end
            if (sq.size() > 0 && sq[0].cyc == cyc) begin
                s = sq.pop_front();
                chk("running", W'(running), W'(s.running));
                chk("done", W'(done), W'(s.done));
                chk("full", W'(full), W'(s.full));
                chk("trig_ptr", W'(trig_ptr), W'(s.tptr));
                chk("trig_ts", W'(trig_ts), W'(s.ts));
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(negedge adc_clk);
        chk("rst_wr_en", W'(wr_en), W'(0));
        chk("rst_running", W'(running), W'(0));
        chk("rst_done", W'(done), W'(0));
        chk("rst_full", W'(full), W'(0));
        chk("rst_wr_addr", W'(wr_addr), W'(0));
        chk("rst_trig_ptr", W'(trig_ptr), W'(0));
        chk("rst_trig_ts", W'(trig_ts), W'(0));
        adc_rst_n = 1'b1; rst_cyc = cyc; mon_en = 1'b1;

        // one-shot, every sample kept: 16 writes then done with full
        adc_valid = 1'b1; set_cfg(0, 8'hFF, 0, 0);
        arm = 1'b1; tick(); repeat (20) tick();
        chk("m0_done", W'(done), W'(1));
        chk("m0_full", W'(full), W'(1));
        chk("m0_running", W'(running), W'(0));

        // one-shot with decim=2
        set_cfg(0, 8'hFF, 2, 0);
        arm = 1'b1; tick(); repeat (60) tick();
        chk("m0_decim_done", W'(done), W'(1));

        // pre-trigger, pre_len=4, trigger after 20 writes
        set_cfg(2, 8'hFF, 0, 4);
        arm = 1'b1; tick(); repeat (20) tick();
        trig = 1'b1; tick(); repeat (14) tick();
        chk("m2_trig_ptr", W'(trig_ptr), W'(4));
        chk("m2_done", W'(done), W'(1));
        chk("m2_full", W'(full), W'(1));

        // continuous ring, then abort
        set_cfg(1, 8'hFF, 0, 0);
        arm = 1'b1; tick(); repeat (40) tick();
        chk("m1_running", W'(running), W'(1));
        stop = 1'b1; tick();
        chk("stop_running", W'(running), W'(0));
        chk("stop_done", W'(done), W'(0));

        // lane mask: only lane 0 passes
        set_cfg(0, 8'h01, 0, 0);
        arm = 1'b1; tick(); repeat (5) tick();
        chk("mask_wr_en", W'(wr_en), W'(1));
        chk("mask_upper_zero", W'(wr_data[W-1:DW]), W'(0));

        // arm and trig together in pre-trigger mode: trigger ignored
        set_cfg(2, 8'hFF, 0, 4);
        arm = 1'b1; trig = 1'b1; tick(); repeat (20) tick();
        chk("armtrig_running", W'(running), W'(1));
        chk("armtrig_done", W'(done), W'(0));

        // reserved mode runs as one-shot; pre_len=0 gives a full post-trigger buffer
        set_cfg(3, 8'hFF, 1, 0);
        arm = 1'b1; tick(); repeat (40) tick();
        chk("m3_done", W'(done), W'(1));
        set_cfg(2, 8'hA5, 0, 0);
        arm = 1'b1; tick(); repeat (3) tick();
        trig = 1'b1; tick(); repeat (20) tick();
        chk("pre0_done", W'(done), W'(1));
        chk("pre0_full", W'(full), W'(1));

        // randomized traffic; decim only changes together with arm
        for (int i = 0; i < 2000; i++) begin
            adc_valid = ($urandom_range(3) != 0);
            mode = 2'($urandom_range(3));
            chan_mask = NCH'($urandom);
            pre_len = AW'($urandom);
            arm = ($urandom_range(39) == 0);
            if (arm) decim = RW'($urandom_range(3));
            trig = ($urandom_range(9) == 0);
            stop = ($urandom_range(79) == 0);
            tick();
        end

        // asynchronous reset in the middle of a one-shot capture
        adc_valid = 1'b1; set_cfg(0, 8'hFF, 0, 0);
        arm = 1'b1; tick(); repeat (5) tick();
        chk("pre_reset_wr_en", W'(wr_en), W'(1));
        #2;
        mon_en = 1'b0; adc_rst_n = 1'b0;
        #1;
        chk("async_wr_en", W'(wr_en), W'(0));
        chk("async_running", W'(running), W'(0));
        chk("async_wr_addr", W'(wr_addr), W'(0));
        chk("async_wr_data", wr_data, W'(0));
        chk("async_trig_ts", W'(trig_ts), W'(0));
        wq.delete(); sq.delete(); model_reset();
        @(negedge adc_clk);
        adc_rst_n = 1'b1; rst_cyc = cyc; mon_en = 1'b1;

        // pre-trigger capture after reset exercises the timestamp path
        set_cfg(2, 8'hFF, 0, 8);
        repeat (3) tick();
        arm = 1'b1; tick(); repeat (11) tick();
        trig = 1'b1; tick(); repeat (12) tick();
        chk("post_reset_done", W'(done), W'(1));

        stop = 1'b1; tick(); repeat (3) tick();
        chk("drain_wq", W'(wq.size()), W'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
